// File: rtl/periph_bus_decoder.sv
// periph_bus_decoder
//   Memory-mapped decoder and strobe generator between the nanoV CPU bus and
//   up to NUM_PERIPH peripheral slots laid out at BASE_ADDR + i*2^STRIDE_LOG2
//   inside the region [BASE_ADDR, BASE_ADDR + 2^REGION_LOG2).
//
//   state      | meaning
//   -----------+---------------------------------------------------------
//   S_NONE     | last address outside the peripheral region (RAM/flash)
//   S_UNMAPPED | last address inside the region but not a valid slot
//   S_SLOT     | last address hit a slot; sel_q holds its one-hot select
//
// Ports
//   clk, rst      system clock, synchronous active-high reset
//   is_addr       address-valid strobe, addr_in sampled when high
//   is_data       write-data strobe, cpu_wdata sampled when high
//   is_data_in    read-consume strobe
//   slot_rdata    packed per-slot read data, slot i at [i*DATA_W +: DATA_W]
//   cpu_rdata     read data of the selected slot, 0 when nothing selected
//   sel           registered one-hot slot select
//   wr_stb/rd_stb one-cycle write / read-consume pulses per slot
//   wdata         registered write data
//   err_clr       clears the sticky error flag
//   unmapped_err  sticky unmapped-access flag
//   err_addr      address of the first unmapped access since the last clear
module periph_bus_decoder #(
  parameter int unsigned       NUM_PERIPH  = 8,
  parameter int unsigned       ADDR_W      = 32,
  parameter int unsigned       DATA_W      = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = 32'h1000_0000,
  parameter int unsigned       STRIDE_LOG2 = 2,
  parameter int unsigned       REGION_LOG2 = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         is_addr,
  input  logic [ADDR_W-1:0]            addr_in,
  input  logic                         is_data,
  input  logic [DATA_W-1:0]            cpu_wdata,
  input  logic                         is_data_in,
  input  logic [NUM_PERIPH*DATA_W-1:0] slot_rdata,
  output logic [DATA_W-1:0]            cpu_rdata,
  output logic [NUM_PERIPH-1:0]        sel,
  output logic [NUM_PERIPH-1:0]        wr_stb,
  output logic [NUM_PERIPH-1:0]        rd_stb,
  output logic [DATA_W-1:0]            wdata,
  input  logic                         err_clr,
  output logic                         unmapped_err,
  output logic [ADDR_W-1:0]            err_addr
);

  localparam logic [1:0] S_NONE     = 2'd0;
  localparam logic [1:0] S_UNMAPPED = 2'd1;
  localparam logic [1:0] S_SLOT     = 2'd2;

  // One bit wider than the address so a region covering the whole space
  // still has a representable size.
  localparam logic [ADDR_W:0]   REGION_SIZE = {{ADDR_W{1'b0}}, 1'b1} << REGION_LOG2;
  localparam logic [ADDR_W-1:0] STRIDE_MASK =
      ({{(ADDR_W-1){1'b0}}, 1'b1} << STRIDE_LOG2) - {{(ADDR_W-1){1'b0}}, 1'b1};

  logic [1:0]            state_q, state_d;
  logic [NUM_PERIPH-1:0] sel_q, sel_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [NUM_PERIPH-1:0] wr_stb_q, wr_stb_d;
  logic [NUM_PERIPH-1:0] rd_stb_q, rd_stb_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic                  err_q, err_d;
  logic [ADDR_W-1:0]     err_addr_q, err_addr_d;

  logic [ADDR_W-1:0]     offset;
  logic [ADDR_W-1:0]     idx;
  logic                  in_region;
  logic                  aligned;
  logic                  hit;
  logic [NUM_PERIPH-1:0] onehot;
  logic                  err_event;

  // Address decode. The >= check guards against offset wrapping for
  // addresses below the base.
  assign offset    = addr_in - BASE_ADDR;
  assign idx       = offset >> STRIDE_LOG2;
  assign in_region = (addr_in >= BASE_ADDR) && ({1'b0, offset} < REGION_SIZE);
  assign aligned   = (offset & STRIDE_MASK) == '0;
  assign hit       = in_region && aligned && (idx < ADDR_W'(NUM_PERIPH));

  always_comb begin
    onehot = '0;
    for (int i = 0; i < int'(NUM_PERIPH); i++) begin
      onehot[i] = (idx == ADDR_W'(i));
    end
  end

  // Decode state and latched address. Only is_addr moves them, so strobes
  // issued in the same cycle still see the previous select.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    addr_d  = addr_q;
    if (is_addr) begin
      addr_d = addr_in;
      if (hit) begin
        state_d = S_SLOT;
        sel_d   = onehot;
      end else if (in_region) begin
        state_d = S_UNMAPPED;
        sel_d   = '0;
      end else begin
        state_d = S_NONE;
        sel_d   = '0;
      end
    end
  end

  always_comb begin
    wr_stb_d = is_data    ? sel_q : '0;
    rd_stb_d = is_data_in ? sel_q : '0;
    wdata_d  = is_data    ? cpu_wdata : wdata_q;
  end

  // Sticky error. A new error in the same cycle as err_clr wins and
  // re-captures the address, since the clear would otherwise discard it.
  assign err_event = (state_q == S_UNMAPPED) && (is_data || is_data_in);

  always_comb begin
    err_d      = err_q;
    err_addr_d = err_addr_q;
    if (err_event) begin
      err_d = 1'b1;
      if (!err_q || err_clr) begin
        err_addr_d = addr_q;
      end
    end else if (err_clr) begin
      err_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_NONE;
      sel_q      <= '0;
      addr_q     <= '0;
      wr_stb_q   <= '0;
      rd_stb_q   <= '0;
      wdata_q    <= '0;
      err_q      <= 1'b0;
      err_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      addr_q     <= addr_d;
      wr_stb_q   <= wr_stb_d;
      rd_stb_q   <= rd_stb_d;
      wdata_q    <= wdata_d;
      err_q      <= err_d;
      err_addr_q <= err_addr_d;
    end
  end

  // Select is one-hot (or zero), so an AND-OR mux is sufficient.
  always_comb begin
    cpu_rdata = '0;
    for (int i = 0; i < int'(NUM_PERIPH); i++) begin
      if (sel_q[i]) begin
        cpu_rdata = cpu_rdata | slot_rdata[i*DATA_W +: DATA_W];
      end
    end
  end

  assign sel          = sel_q;
  assign wr_stb       = wr_stb_q;
  assign rd_stb       = rd_stb_q;
  assign wdata        = wdata_q;
  assign unmapped_err = err_q;
  assign err_addr     = err_addr_q;

endmodule
